// File: rtl/slot_spin_sequencer.sv
// Slot machine game sequencer.
//
// Accepts debounced spin/coin pulses, spins three reels with staggered stops whose
// duration is jittered by a free-running LFSR, scores the final reels and keeps the
// credit count. Outputs feed the 4-digit seven-segment display controller:
// reel0/reel1/reel2 -> num_in1/num_in/num_in2, credits -> num_in3.
//
// Ports:
//   clock     in   system clock, rising edge
//   reset     in   asynchronous active-high reset
//   spin      in   one-cycle spin request
//   coin      in   one-cycle coin insert
//   reel0..2  out  reel symbols (3 bits each)
//   credits   out  credit count, saturating 0..7
//   busy      out  high whenever a spin is in progress
//   win_code  out  last result: 0 none, 1 pair, 2 jackpot
//   win_pulse out  one-cycle pulse on a pair or jackpot result
module slot_spin_sequencer #(
  parameter int unsigned TICK_DIV      = 5000000,
  parameter int unsigned STOP_TICKS    = 20,
  parameter int unsigned STAGGER_TICKS = 8,
  parameter int unsigned CREDIT_INIT   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       spin,
  input  logic       coin,
  output logic [2:0] reel0,
  output logic [2:0] reel1,
  output logic [2:0] reel2,
  output logic [2:0] credits,
  output logic       busy,
  output logic [1:0] win_code,
  output logic       win_pulse
);

  localparam int unsigned DivW = $clog2(TICK_DIV);
  localparam logic [DivW-1:0] DivMax = DivW'(TICK_DIV - 1);
  localparam logic [7:0] StopTicks = 8'(STOP_TICKS);
  localparam logic [7:0] StaggerTicks = 8'(STAGGER_TICKS);

  typedef enum logic [2:0] {
    StIdle,
    StSpinAll,
    StSpin2,
    StSpin1,
    StResult
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [7:0]      tick_cnt_q, tick_cnt_d;
  logic [7:0]      lfsr_q, lfsr_d;
  logic [2:0]      jitter_q, jitter_d;
  logic [2:0]      reel0_q, reel0_d;
  logic [2:0]      reel1_q, reel1_d;
  logic [2:0]      reel2_q, reel2_d;
  logic [2:0]      credits_q, credits_d;
  logic            busy_q, busy_d;
  logic [1:0]      win_code_q, win_code_d;
  logic            win_pulse_q, win_pulse_d;

  logic       tick;
  logic [7:0] tick_inc;
  logic [7:0] stop0, stop1, stop2;
  logic       accept;
  logic [2:0] payout;
  logic [3:0] cred_sum;
  logic       eq01, eq12, eq02;

  assign tick     = (state_q != StIdle) && (div_q == DivMax);
  assign tick_inc = tick_cnt_q + 8'd1;
  assign stop0    = StopTicks + {5'd0, jitter_q};
  assign stop1    = stop0 + StaggerTicks;
  assign stop2    = stop1 + StaggerTicks;

  assign eq01 = (reel0_q == reel1_q);
  assign eq12 = (reel1_q == reel2_q);
  assign eq02 = (reel0_q == reel2_q);

  // Free-running LFSR; it never stalls, so spin timing relative to reset picks the jitter.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    tick_cnt_d  = tick_cnt_q;
    jitter_d    = jitter_q;
    reel0_d     = reel0_q;
    reel1_d     = reel1_q;
    reel2_d     = reel2_q;
    win_code_d  = win_code_q;
    win_pulse_d = 1'b0;
    accept      = 1'b0;
    payout      = 3'd0;

    if (state_q != StIdle) begin
      div_d = tick ? '0 : div_q + DivW'(1);
    end

    unique case (state_q)
      StIdle: begin
        // Credits are sampled before any same-cycle coin is added.
        if (spin && (credits_q != 3'd0)) begin
          accept     = 1'b1;
          state_d    = StSpinAll;
          div_d      = '0;
          tick_cnt_d = 8'd0;
          jitter_d   = lfsr_q[2:0];
        end
      end
      StSpinAll: begin
        if (tick) begin
          tick_cnt_d = tick_inc;
          reel0_d    = reel0_q + 3'd1;
          reel1_d    = reel1_q + 3'd3;
          reel2_d    = reel2_q + 3'd5;
          if (tick_inc == stop0) state_d = StSpin2;
        end
      end
      StSpin2: begin
        if (tick) begin
          tick_cnt_d = tick_inc;
          reel1_d    = reel1_q + 3'd3;
          reel2_d    = reel2_q + 3'd5;
          if (tick_inc == stop1) state_d = StSpin1;
        end
      end
      StSpin1: begin
        if (tick) begin
          tick_cnt_d = tick_inc;
          reel2_d    = reel2_q + 3'd5;
          if (tick_inc == stop2) state_d = StResult;
        end
      end
      StResult: begin
        state_d = StIdle;
        if (eq01 && eq12) begin
          win_code_d  = 2'd2;
          win_pulse_d = 1'b1;
          payout      = 3'd3;
        end else if (eq01 || eq12 || eq02) begin
          win_code_d  = 2'd1;
          win_pulse_d = 1'b1;
          payout      = 3'd1;
        end else begin
          win_code_d  = 2'd0;
        end
      end
      default: state_d = StIdle;
    endcase

    // accept implies credits_q >= 1, so the subtraction cannot wrap; max sum is 11.
    cred_sum  = {1'b0, credits_q} + {3'd0, coin} + {1'b0, payout} - {3'd0, accept};
    credits_d = (cred_sum > 4'd7) ? 3'd7 : cred_sum[2:0];

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      div_q       <= '0;
      tick_cnt_q  <= 8'd0;
      lfsr_q      <= 8'h01;
      jitter_q    <= 3'd0;
      reel0_q     <= 3'd0;
      reel1_q     <= 3'd0;
      reel2_q     <= 3'd0;
      credits_q   <= 3'(CREDIT_INIT);
      busy_q      <= 1'b0;
      win_code_q  <= 2'd0;
      win_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      tick_cnt_q  <= tick_cnt_d;
      lfsr_q      <= lfsr_d;
      jitter_q    <= jitter_d;
      reel0_q     <= reel0_d;
      reel1_q     <= reel1_d;
      reel2_q     <= reel2_d;
      credits_q   <= credits_d;
      busy_q      <= busy_d;
      win_code_q  <= win_code_d;
      win_pulse_q <= win_pulse_d;
    end
  end

  assign reel0     = reel0_q;
  assign reel1     = reel1_q;
  assign reel2     = reel2_q;
  assign credits   = credits_q;
  assign busy      = busy_q;
  assign win_code  = win_code_q;
  assign win_pulse = win_pulse_q;

endmodule

// File: tb/tb_slot_spin_sequencer.sv
// Bench for slot_spin_sequencer. Four instances share clock and reset:
//   0: stop/stagger 2/2, 1: 4/4, 2: 8/8 (all CREDIT_INIT 3), 3: 2/2 with CREDIT_INIT 0.
// Expected spin results are queued when a spin is driven and checked when busy falls.
module tb_slot_spin_sequencer;

  localparam int NumDut = 4;
  localparam int unsigned TickDiv = 4;

  typedef struct {
    int          inst;
    logic [2:0]  r0;
    logic [2:0]  r1;
    logic [2:0]  r2;
    logic [1:0]  wc;
    logic        pulse;
    logic [2:0]  cred;
    int unsigned busy_len;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       spin      [NumDut];
  logic       coin      [NumDut];
  logic [2:0] reel0     [NumDut];
  logic [2:0] reel1     [NumDut];
  logic [2:0] reel2     [NumDut];
  logic [2:0] credits   [NumDut];
  logic       busy      [NumDut];
  logic [1:0] win_code  [NumDut];
  logic       win_pulse [NumDut];

  always #5 clock = ~clock;

  for (genvar g = 0; g < NumDut; g++) begin : g_dut
    localparam int unsigned Stop = (g == 3) ? 2 : (2 << g);
    localparam int unsigned Cinit = (g == 3) ? 0 : 3;
    slot_spin_sequencer #(
      .TICK_DIV     (TickDiv),
      .STOP_TICKS   (Stop),
      .STAGGER_TICKS(Stop),
      .CREDIT_INIT  (Cinit)
    ) u_dut (
      .clock    (clock),
      .reset    (reset),
      .spin     (spin[g]),
      .coin     (coin[g]),
      .reel0    (reel0[g]),
      .reel1    (reel1[g]),
      .reel2    (reel2[g]),
      .credits  (credits[g]),
      .busy     (busy[g]),
      .win_code (win_code[g]),
      .win_pulse(win_pulse[g])
    );
  end

  int n_checks = 0;
  int n_fail = 0;

  vec_t        exp_q[$];
  logic        busy_prev [NumDut];
  int unsigned busy_run  [NumDut];
  int unsigned pulse_cnt [NumDut];
  int unsigned pulse_exp [NumDut];

  // Bench-side model state: LFSR, held reels and credits per instance.
  logic [7:0]  m_lfsr;
  int unsigned m_r0   [NumDut];
  int unsigned m_r1   [NumDut];
  int unsigned m_r2   [NumDut];
  int unsigned m_cred [NumDut];

  always @(posedge clock or posedge reset) begin
    if (reset) m_lfsr <= 8'h01;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  function automatic int unsigned stop_of(input int i);
    return (i == 3) ? 2 : (2 << i);
  endfunction

  function automatic int unsigned cred_init_of(input int i);
    return (i == 3) ? 0 : 3;
  endfunction

  task automatic check(input string name, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_reset_vals(input int i, input string tag);
    check($sformatf("%s_reel0[%0d]", tag, i), reel0[i], 0);
    check($sformatf("%s_reel1[%0d]", tag, i), reel1[i], 0);
    check($sformatf("%s_reel2[%0d]", tag, i), reel2[i], 0);
    check($sformatf("%s_credits[%0d]", tag, i), credits[i], cred_init_of(i));
    check($sformatf("%s_busy[%0d]", tag, i), busy[i], 0);
    check($sformatf("%s_win_code[%0d]", tag, i), win_code[i], 0);
    check($sformatf("%s_win_pulse[%0d]", tag, i), win_pulse[i], 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NumDut; i++) begin
      m_r0[i] = 0;
      m_r1[i] = 0;
      m_r2[i] = 0;
      m_cred[i] = cred_init_of(i);
    end
  endtask

  // Call at a negedge, just before driving the accepted spin.
  task automatic push_spin(input int i, input logic with_coin);
    int unsigned jit, t0, t1, t2, acc, pay;
    vec_t v;
    jit = m_lfsr[2:0];
    t0 = stop_of(i) + jit;
    t1 = t0 + stop_of(i);
    t2 = t1 + stop_of(i);
    v.inst = i;
    v.r0 = 3'((m_r0[i] + t0) % 8);
    v.r1 = 3'((m_r1[i] + 3 * t1) % 8);
    v.r2 = 3'((m_r2[i] + 5 * t2) % 8);
    if (v.r0 == v.r1 && v.r1 == v.r2) begin
      v.wc = 2'd2;
      pay = 3;
    end else if (v.r0 == v.r1 || v.r1 == v.r2 || v.r0 == v.r2) begin
      v.wc = 2'd1;
      pay = 1;
    end else begin
      v.wc = 2'd0;
      pay = 0;
    end
    v.pulse = (v.wc != 2'd0);
    acc = m_cred[i] - 1 + (with_coin ? 1 : 0);
    v.cred = 3'((acc + pay > 7) ? 7 : acc + pay);
    v.busy_len = t2 * TickDiv + 1;
    exp_q.push_back(v);
    m_r0[i] = v.r0;
    m_r1[i] = v.r1;
    m_r2[i] = v.r2;
    m_cred[i] = v.cred;
  endtask

  task automatic score(input int i);
    int idx;
    vec_t v;
    idx = -1;
    foreach (exp_q[k]) if (idx < 0 && exp_q[k].inst == i) idx = k;
    if (idx < 0) begin
      check($sformatf("unexpected_result[%0d]", i), 1, 0);
      return;
    end
    v = exp_q[idx];
    exp_q.delete(idx);
    check($sformatf("res_reel0[%0d]", i), reel0[i], v.r0);
    check($sformatf("res_reel1[%0d]", i), reel1[i], v.r1);
    check($sformatf("res_reel2[%0d]", i), reel2[i], v.r2);
    check($sformatf("res_win_code[%0d]", i), win_code[i], v.wc);
    check($sformatf("res_win_pulse[%0d]", i), win_pulse[i], v.pulse);
    check($sformatf("res_credits[%0d]", i), credits[i], v.cred);
    check($sformatf("res_busy_len[%0d]", i), busy_run[i], v.busy_len);
    if (v.pulse) pulse_exp[i]++;
  endtask

  // Monitor: detects the end of each spin (busy falling) and scores it.
  initial begin
    for (int i = 0; i < NumDut; i++) begin
      busy_prev[i] = 1'b0;
      busy_run[i] = 0;
      pulse_cnt[i] = 0;
      pulse_exp[i] = 0;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < NumDut; i++) begin
        if (reset) begin
          busy_prev[i] = 1'b0;
          busy_run[i] = 0;
        end else begin
          if (win_pulse[i]) pulse_cnt[i]++;
          if (busy[i]) begin
            busy_run[i]++;
          end else if (busy_prev[i]) begin
            score(i);
            busy_run[i] = 0;
          end
          busy_prev[i] = busy[i];
        end
      end
    end
  end

  task automatic drain(input string tag);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 400) begin
      @(negedge clock);
      cyc++;
    end
    @(negedge clock);
    check($sformatf("%s_pending_results", tag), exp_q.size(), 0);
  endtask

  // Assert reset, hold it across two negedges, release mid-cycle, realign to a negedge.
  task automatic reset_pulse();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1);
  end

  vec_t tab[3];
  int unsigned exp_cred;
  int unsigned jit;

  initial begin
    // First-spin expectations, jitter 0 (lfsr 0x08 at the accepting edge).
    tab[0] = '{inst: 0, r0: 3'd2, r1: 3'd4, r2: 3'd6, wc: 2'd0, pulse: 1'b0,
               cred: 3'd2, busy_len: 25};
    tab[1] = '{inst: 1, r0: 3'd4, r1: 3'd0, r2: 3'd4, wc: 2'd1, pulse: 1'b1,
               cred: 3'd3, busy_len: 49};
    tab[2] = '{inst: 2, r0: 3'd0, r1: 3'd0, r2: 3'd0, wc: 2'd2, pulse: 1'b1,
               cred: 3'd5, busy_len: 97};

    for (int i = 0; i < NumDut; i++) begin
      spin[i] = 1'b0;
      coin[i] = 1'b0;
    end
    model_reset();

    // Reset values, then 10 idle cycles.
    @(negedge clock);
    @(negedge clock);
    for (int i = 0; i < NumDut; i++) check_reset_vals(i, "in_reset");
    reset = 1'b0;
    @(posedge clock);
    #1 check("lfsr_after_1st_edge", g_dut[0].u_dut.lfsr_q, 8'h02);
    repeat (10) @(negedge clock);
    for (int i = 0; i < NumDut; i++) check_reset_vals(i, "idle10");

    // Table-driven first spin on instances 0..2, sampled at the 4th edge after release.
    reset_pulse();
    @(negedge clock);
    @(negedge clock);
    check("lfsr_at_spin", g_dut[0].u_dut.lfsr_q, 8'h08);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(tab[i]);
      m_r0[i] = tab[i].r0;
      m_r1[i] = tab[i].r1;
      m_r2[i] = tab[i].r2;
      m_cred[i] = tab[i].cred;
      spin[i] = 1'b1;
    end
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      spin[i] = 1'b0;
      check($sformatf("accept_credits[%0d]", i), credits[i], 2);
      check($sformatf("accept_busy[%0d]", i), busy[i], 1);
    end
    drain("first_spin");

    // Coin and spin together at credits 2, then a spin while busy.
    check("pre_coin_spin_credits", credits[0], 2);
    push_spin(0, 1'b1);
    spin[0] = 1'b1;
    coin[0] = 1'b1;
    @(negedge clock);
    spin[0] = 1'b0;
    coin[0] = 1'b0;
    check("coin_spin_credits", credits[0], 2);
    check("coin_spin_busy", busy[0], 1);
    repeat (3) @(negedge clock);
    spin[0] = 1'b1;
    @(negedge clock);
    spin[0] = 1'b0;
    check("spin_while_busy_credits", credits[0], 2);
    check("spin_while_busy_busy", busy[0], 1);
    drain("coin_spin");

    // Reset in the middle of SPIN_2, then a clean spin from 0/0/0.
    jit = m_lfsr[2:0];
    push_spin(0, 1'b0);
    spin[0] = 1'b1;
    @(negedge clock);
    spin[0] = 1'b0;
    repeat ((2 + jit) * TickDiv + 3) @(negedge clock);
    check("mid_spin2_busy", busy[0], 1);
    #2 reset = 1'b1;
    #1;
    for (int i = 0; i < NumDut; i++) check_reset_vals(i, "async_reset");
    check("async_reset_lfsr", g_dut[0].u_dut.lfsr_q, 8'h01);
    exp_q.delete();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    @(negedge clock);
    push_spin(0, 1'b0);
    spin[0] = 1'b1;
    @(negedge clock);
    spin[0] = 1'b0;
    check("post_reset_accept_credits", credits[0], 2);
    drain("post_reset");

    // Instance 3 starts with 0 credits.
    spin[3] = 1'b1;
    @(negedge clock);
    spin[3] = 1'b0;
    check("zero_cred_spin_busy", busy[3], 0);
    check("zero_cred_spin_credits", credits[3], 0);
    repeat (3) @(negedge clock);
    check("zero_cred_spin_busy_later", busy[3], 0);
    spin[3] = 1'b1;
    coin[3] = 1'b1;
    @(negedge clock);
    spin[3] = 1'b0;
    check("zero_cred_coin_spin_busy", busy[3], 0);
    check("zero_cred_coin_spin_credits", credits[3], 1);
    exp_cred = 1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      exp_cred = (exp_cred >= 7) ? 7 : exp_cred + 1;
      check($sformatf("coin_sat_step%0d", k), credits[3], exp_cred);
    end
    coin[3] = 1'b0;
    @(negedge clock);
    check("coin_sat_final", credits[3], 7);
    check("zero_cred_never_busy", busy[3], 0);

    for (int i = 0; i < NumDut; i++) begin
      check($sformatf("win_pulse_total[%0d]", i), pulse_cnt[i], pulse_exp[i]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
